// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
// Lane controller for the car park entry and exit barriers. It debounces the
// loop (presence) and pass (post-barrier) sensors of each lane and runs one
// state machine per lane. Entry is admitted only if the downstream counter
// reports space for the car's class. Each completed passage becomes exactly one
// single-cycle car_entered / car_exited pulse. When both lanes finish on the
// same cycle, the exit pulse goes first.
//
// Ports
//   clk                   system clock, rising edge
//   reset                 synchronous active-low reset
//   ent_loop / ext_loop   raw presence sensors
//   ent_pass / ext_pass   raw post-barrier sensors
//   *_tag_valid/*_tag_uni card-reader strobe and class (1 = university car)
//   uni_is_vacated_space  university space available (sampled on entry tag)
//   is_vacated_space      free space available (sampled on entry tag)
//   car_entered/exited    single-cycle passage events
//   is_uni_car_*          class of the event, 0 when no event
//   *_barrier_open        barrier drive, 1 = open
//   ent_reject            level, entry refused for lack of space
//   *_timeout             single-cycle pulse, barrier closed without passage
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int OPEN_CYCLES     = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic ent_loop,
   input  logic ent_pass,
   input  logic ent_tag_valid,
   input  logic ent_tag_uni,
   input  logic ext_loop,
   input  logic ext_pass,
   input  logic ext_tag_valid,
   input  logic ext_tag_uni,
   input  logic uni_is_vacated_space,
   input  logic is_vacated_space,
   output logic car_entered,
   output logic is_uni_car_entered,
   output logic car_exited,
   output logic is_uni_car_exited,
   output logic ent_barrier_open,
   output logic ext_barrier_open,
   output logic ent_reject,
   output logic ent_timeout,
   output logic ext_timeout
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(OPEN_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WAIT_TAG, OPEN, CLOSE, REJECT} state_t;

   // ---------------- sensor debouncers ----------------
   // bit order: 0 ent_loop, 1 ent_pass, 2 ext_loop, 3 ext_pass
   logic [3:0] raw;
   logic [3:0] filt;
   logic [3:0] rise;   // one cycle after the filtered value flips to 1

   assign raw = {ext_pass, ext_loop, ent_pass, ent_loop};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_deb
         logic [DW-1:0] cnt_reg;
         logic          filt_reg;
         logic          rise_reg;

         always_ff @(posedge clk) begin
            if (!reset) begin
               cnt_reg  <= '0;
               filt_reg <= 1'b0;
               rise_reg <= 1'b0;
            end else begin
               rise_reg <= 1'b0;
               if (raw[gi] == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                  // this edge is the DEBOUNCE_CYCLES-th differing sample
                  cnt_reg  <= '0;
                  filt_reg <= raw[gi];
                  rise_reg <= raw[gi];
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign filt[gi] = filt_reg;
         assign rise[gi] = rise_reg;
      end
   endgenerate

   // ---------------- entry lane ----------------
   state_t        ent_state_reg, ent_state_next;
   logic [TW-1:0] ent_timer_reg;
   logic          ent_uni_reg;
   logic          ent_space_ok, ent_expire, ent_done;

   assign ent_space_ok = ent_tag_uni ? uni_is_vacated_space : is_vacated_space;
   assign ent_expire   = (ent_timer_reg == TW'(OPEN_CYCLES - 1));
   // a pass in the expiry cycle still counts as a passage
   assign ent_done     = (ent_state_reg == OPEN) && rise[1];

   always_ff @(posedge clk) begin
      if (!reset) ent_state_reg <= IDLE;
      else        ent_state_reg <= ent_state_next;
   end

   always_comb begin
      ent_state_next = ent_state_reg;
      case (ent_state_reg)
         IDLE:     if (filt[0]) ent_state_next = WAIT_TAG;
         WAIT_TAG: begin
            if (ent_tag_valid) ent_state_next = ent_space_ok ? OPEN : REJECT;
            else if (!filt[0]) ent_state_next = IDLE;
         end
         OPEN:     if (rise[1] || ent_expire) ent_state_next = CLOSE;
         CLOSE:    if (!filt[0] && !filt[1]) ent_state_next = IDLE;
         REJECT:   if (!filt[0]) ent_state_next = IDLE;
         default:  ent_state_next = IDLE;
      endcase
   end

   always_comb begin
      ent_barrier_open = (ent_state_reg == OPEN);
      ent_reject       = (ent_state_reg == REJECT);
   end

   // ---------------- exit lane ----------------
   state_t        ext_state_reg, ext_state_next;
   logic [TW-1:0] ext_timer_reg;
   logic          ext_uni_reg;
   logic          ext_expire, ext_done;

   assign ext_expire = (ext_timer_reg == TW'(OPEN_CYCLES - 1));
   assign ext_done   = (ext_state_reg == OPEN) && rise[3];

   always_ff @(posedge clk) begin
      if (!reset) ext_state_reg <= IDLE;
      else        ext_state_reg <= ext_state_next;
   end

   always_comb begin
      ext_state_next = ext_state_reg;
      case (ext_state_reg)
         IDLE:     if (filt[2]) ext_state_next = WAIT_TAG;
         WAIT_TAG: begin
            if (ext_tag_valid) ext_state_next = OPEN;
            else if (!filt[2]) ext_state_next = IDLE;
         end
         OPEN:     if (rise[3] || ext_expire) ext_state_next = CLOSE;
         CLOSE:    if (!filt[2] && !filt[3]) ext_state_next = IDLE;
         default:  ext_state_next = IDLE;
      endcase
   end

   always_comb begin
      ext_barrier_open = (ext_state_reg == OPEN);
   end

   // ---------------- timers, class latches, timeout pulses ----------------
   logic ent_timeout_reg, ext_timeout_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_timer_reg   <= '0;
         ext_timer_reg   <= '0;
         ent_uni_reg     <= 1'b0;
         ext_uni_reg     <= 1'b0;
         ent_timeout_reg <= 1'b0;
         ext_timeout_reg <= 1'b0;
      end else begin
         if (ent_state_reg == WAIT_TAG && ent_tag_valid) begin
            ent_timer_reg <= '0;
            ent_uni_reg   <= ent_tag_uni;
         end else if (ent_state_reg == OPEN) begin
            ent_timer_reg <= ent_timer_reg + 1'b1;
         end
         if (ext_state_reg == WAIT_TAG && ext_tag_valid) begin
            ext_timer_reg <= '0;
            ext_uni_reg   <= ext_tag_uni;
         end else if (ext_state_reg == OPEN) begin
            ext_timer_reg <= ext_timer_reg + 1'b1;
         end
         ent_timeout_reg <= (ent_state_reg == OPEN) && ent_expire && !rise[1];
         ext_timeout_reg <= (ext_state_reg == OPEN) && ext_expire && !rise[3];
      end
   end

   assign ent_timeout = ent_timeout_reg;
   assign ext_timeout = ext_timeout_reg;

   // ---------------- event arbiter ----------------
   // Exit wins a collision so the freed space is counted first; the losing
   // entry is parked for exactly one cycle. The class latch stays stable while
   // pending because a new entry tag needs the lane to pass through IDLE first.
   logic ent_pend_reg;
   logic ent_req, ext_req;
   logic car_entered_reg, uni_entered_reg, car_exited_reg, uni_exited_reg;

   assign ent_req = ent_pend_reg | ent_done;
   assign ext_req = ext_done;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_pend_reg    <= 1'b0;
         car_entered_reg <= 1'b0;
         uni_entered_reg <= 1'b0;
         car_exited_reg  <= 1'b0;
         uni_exited_reg  <= 1'b0;
      end else begin
         car_exited_reg  <= ext_req;
         uni_exited_reg  <= ext_req & ext_uni_reg;
         car_entered_reg <= ent_req & ~ext_req;
         uni_entered_reg <= ent_req & ~ext_req & ent_uni_reg;
         ent_pend_reg    <= ent_req & ext_req;
      end
   end

   assign car_entered        = car_entered_reg;
   assign is_uni_car_entered = uni_entered_reg;
   assign car_exited         = car_exited_reg;
   assign is_uni_car_exited  = uni_exited_reg;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
// Scenario tasks drive the lane sensors. The expected event cycles,
// barrier-open durations and timeout cycles come from arithmetic on the
// debounce and open-window timing rules: a raw level first sampled at edge Q
// is filtered at Q+D-1; a tag sampled at edge T opens the barrier for cycles
// T..T+OC-1; a passage counts if its filtered pass edge P <= T+OC-1, and its
// event appears at P+1. A collision with an exit event pushes the entry event
// one cycle later.
// Inputs are driven at the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_parking_gate_ctrl;

   localparam int D  = 4;
   localparam int OC = 16;

   logic clk = 1'b0;
   logic reset;
   logic ent_loop, ent_pass, ent_tag_valid, ent_tag_uni;
   logic ext_loop, ext_pass, ext_tag_valid, ext_tag_uni;
   logic uni_is_vacated_space, is_vacated_space;
   logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
   logic ent_barrier_open, ext_barrier_open, ent_reject, ent_timeout, ext_timeout;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   parking_gate_ctrl #(.DEBOUNCE_CYCLES(D), .OPEN_CYCLES(OC)) dut (
      .clk(clk), .reset(reset),
      .ent_loop(ent_loop), .ent_pass(ent_pass),
      .ent_tag_valid(ent_tag_valid), .ent_tag_uni(ent_tag_uni),
      .ext_loop(ext_loop), .ext_pass(ext_pass),
      .ext_tag_valid(ext_tag_valid), .ext_tag_uni(ext_tag_uni),
      .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
      .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
      .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
      .ent_barrier_open(ent_barrier_open), .ext_barrier_open(ext_barrier_open),
      .ent_reject(ent_reject), .ent_timeout(ent_timeout), .ext_timeout(ext_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n++;

   // observation history, reset per scenario
   int ent_ev[$];
   bit ent_ev_uni[$];
   int ext_ev[$];
   bit ext_ev_uni[$];
   int ent_to[$];
   int ext_to[$];
   int ent_open_n, ext_open_n, rej_n, overlap_n, stray_n;

   task automatic clear_hist();
      ent_ev.delete(); ent_ev_uni.delete();
      ext_ev.delete(); ext_ev_uni.delete();
      ent_to.delete(); ext_to.delete();
      ent_open_n = 0; ext_open_n = 0; rej_n = 0; overlap_n = 0; stray_n = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      if (car_entered === 1'b1) begin
         ent_ev.push_back(edge_n);
         ent_ev_uni.push_back(is_uni_car_entered);
      end
      if (car_exited === 1'b1) begin
         ext_ev.push_back(edge_n);
         ext_ev_uni.push_back(is_uni_car_exited);
      end
      if (car_entered === 1'b1 && car_exited === 1'b1) overlap_n++;
      if ((car_entered !== 1'b1 && is_uni_car_entered !== 1'b0) ||
          (car_exited  !== 1'b1 && is_uni_car_exited  !== 1'b0)) stray_n++;
      if (ent_timeout === 1'b1) ent_to.push_back(edge_n);
      if (ext_timeout === 1'b1) ext_to.push_back(edge_n);
      if (ent_barrier_open === 1'b1) ent_open_n++;
      if (ext_barrier_open === 1'b1) ext_open_n++;
      if (ent_reject === 1'b1) rej_n++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drive_quiet();
      ent_loop = 0; ent_pass = 0; ent_tag_valid = 0; ent_tag_uni = 0;
      ext_loop = 0; ext_pass = 0; ext_tag_valid = 0; ext_tag_uni = 0;
      uni_is_vacated_space = 1; is_vacated_space = 1;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      logic [8:0] outs;
      reset = 0;
      ent_loop = 1; ent_pass = 1; ent_tag_valid = 1; ent_tag_uni = 1;
      ext_loop = 1; ext_pass = 1; ext_tag_valid = 1; ext_tag_uni = 1;
      uni_is_vacated_space = 1; is_vacated_space = 1;
      ticks(2);
      outs = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
              ent_barrier_open, ext_barrier_open, ent_reject, ent_timeout, ext_timeout};
      checks++;
      if (outs !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", outs, 9'b0);
      end
      reset = 1;
      drive_quiet();
      clear_hist();
      ticks(3 * D + 4);
      checks++;
      if (ent_open_n + ext_open_n + rej_n + ent_ev.size() + ext_ev.size() != 0) begin
         errors++;
         $display("FAIL reset_idle: got activity open=%0d/%0d rej=%0d ev=%0d/%0d expected none",
                  ent_open_n, ext_open_n, rej_n, ent_ev.size(), ext_ev.size());
      end
      $display("[reset] outputs=%b idle_activity=%0d", outs, ent_open_n + ext_open_n + rej_n);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_entry(input bit uni, input bit sp_uni, input bit sp_free,
                             input int gap, input int pass_len, input string name);
      int  t_edge, p_edge, exp_open, exp_ev_edge, exp_to_edge, r_edge;
      bit  admit, passed;
      clear_hist();
      admit = uni ? sp_uni : sp_free;
      ent_loop = 1;
      ticks(D + 1 + int'($urandom_range(0, 3)));
      ent_tag_valid = 1; ent_tag_uni = uni;
      uni_is_vacated_space = sp_uni; is_vacated_space = sp_free;
      tick();
      t_edge = edge_n;
      // space changes after the tag cycle must not matter
      ent_tag_valid = 0; ent_tag_uni = 1'($urandom);
      uni_is_vacated_space = 1'($urandom); is_vacated_space = 1'($urandom);
      checks++;
      if (ent_barrier_open !== admit) begin
         errors++;
         $display("FAIL %s_open_after_tag: got %b expected %b", name, ent_barrier_open, admit);
      end
      checks++;
      if (ent_reject !== !admit) begin
         errors++;
         $display("FAIL %s_reject_after_tag: got %b expected %b", name, ent_reject, !admit);
      end

      if (admit) begin
         ticks(gap);
         ent_pass = 1;
         ticks(pass_len);
         ent_pass = 0;
         ent_loop = 0;
         ticks(OC + 2 * D + 6);
         p_edge = t_edge + gap + D;
         passed = (pass_len >= D) && (p_edge <= t_edge + OC - 1);
         exp_open    = passed ? (p_edge + 1 - t_edge) : OC;
         exp_ev_edge = p_edge + 1;
         exp_to_edge = t_edge + OC;
         checks++;
         if (ent_open_n != exp_open) begin
            errors++;
            $display("FAIL %s_open_cycles: got %0d expected %0d", name, ent_open_n, exp_open);
         end
         checks++;
         if (ent_ev.size() != (passed ? 1 : 0)) begin
            errors++;
            $display("FAIL %s_event_count: got %0d expected %0d", name, ent_ev.size(), passed ? 1 : 0);
         end else if (passed) begin
            checks++;
            if (ent_ev[0] != exp_ev_edge || ent_ev_uni[0] != uni) begin
               errors++;
               $display("FAIL %s_event: got edge %0d uni %0d expected edge %0d uni %0d",
                        name, ent_ev[0], ent_ev_uni[0], exp_ev_edge, uni);
            end
         end
         checks++;
         if (ent_to.size() != (passed ? 0 : 1)) begin
            errors++;
            $display("FAIL %s_timeout_count: got %0d expected %0d", name, ent_to.size(), passed ? 0 : 1);
         end else if (!passed) begin
            checks++;
            if (ent_to[0] != exp_to_edge) begin
               errors++;
               $display("FAIL %s_timeout_edge: got %0d expected %0d", name, ent_to[0], exp_to_edge);
            end
         end
      end else begin
         ticks(1 + int'($urandom_range(0, 3)));
         ent_loop = 0;
         r_edge = edge_n + 1;
         ticks(D);
         checks++;
         if (ent_reject !== 1'b1) begin
            errors++;
            $display("FAIL %s_reject_hold: got %b expected 1 at edge %0d", name, ent_reject, r_edge + D - 1);
         end
         tick();
         checks++;
         if (ent_reject !== 1'b0) begin
            errors++;
            $display("FAIL %s_reject_clear: got %b expected 0 at edge %0d", name, ent_reject, r_edge + D);
         end
         ticks(4);
         checks++;
         if (ent_open_n != 0 || ent_ev.size() != 0) begin
            errors++;
            $display("FAIL %s_rejected_activity: got open=%0d events=%0d expected 0/0",
                     name, ent_open_n, ent_ev.size());
         end
      end
      checks++;
      if (overlap_n != 0 || stray_n != 0 || ext_ev.size() != 0 || ent_barrier_open !== 1'b0) begin
         errors++;
         $display("FAIL %s_side_effects: got overlap=%0d stray=%0d exits=%0d barrier=%b expected 0/0/0/0",
                  name, overlap_n, stray_n, ext_ev.size(), ent_barrier_open);
      end
      $display("[entry %s] uni=%0d admit=%0d gap=%0d pass_len=%0d events=%0d timeouts=%0d open=%0d",
               name, uni, admit, gap, pass_len, ent_ev.size(), ent_to.size(), ent_open_n);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_exit(input bit uni, input int gap, input int pass_len);
      int t_edge, p_edge, exp_open;
      bit passed;
      clear_hist();
      ext_loop = 1;
      ticks(D + 1 + int'($urandom_range(0, 3)));
      ext_tag_valid = 1; ext_tag_uni = uni;
      uni_is_vacated_space = 0; is_vacated_space = 0;  // exit never checks space
      tick();
      t_edge = edge_n;
      ext_tag_valid = 0;
      checks++;
      if (ext_barrier_open !== 1'b1) begin
         errors++;
         $display("FAIL exit_open_after_tag: got %b expected 1", ext_barrier_open);
      end
      ticks(gap);
      ext_pass = 1;
      ticks(pass_len);
      ext_pass = 0;
      ext_loop = 0;
      ticks(OC + 2 * D + 6);
      p_edge = t_edge + gap + D;
      passed = (pass_len >= D) && (p_edge <= t_edge + OC - 1);
      exp_open = passed ? (p_edge + 1 - t_edge) : OC;
      checks++;
      if (ext_open_n != exp_open) begin
         errors++;
         $display("FAIL exit_open_cycles: got %0d expected %0d", ext_open_n, exp_open);
      end
      checks++;
      if (ext_ev.size() != (passed ? 1 : 0) || ext_to.size() != (passed ? 0 : 1)) begin
         errors++;
         $display("FAIL exit_counts: got events=%0d timeouts=%0d expected %0d/%0d",
                  ext_ev.size(), ext_to.size(), passed ? 1 : 0, passed ? 0 : 1);
      end else begin
         checks++;
         if (passed && (ext_ev[0] != p_edge + 1 || ext_ev_uni[0] != uni)) begin
            errors++;
            $display("FAIL exit_event: got edge %0d uni %0d expected edge %0d uni %0d",
                     ext_ev[0], ext_ev_uni[0], p_edge + 1, uni);
         end else if (!passed && ext_to[0] != t_edge + OC) begin
            errors++;
            $display("FAIL exit_timeout_edge: got %0d expected %0d", ext_to[0], t_edge + OC);
         end
      end
      checks++;
      if (ent_ev.size() != 0 || stray_n != 0) begin
         errors++;
         $display("FAIL exit_side_effects: got entries=%0d stray=%0d expected 0/0", ent_ev.size(), stray_n);
      end
      $display("[exit] uni=%0d gap=%0d pass_len=%0d events=%0d timeouts=%0d open=%0d",
               uni, gap, pass_len, ext_ev.size(), ext_to.size(), ext_open_n);
   endtask

   // ---------------------------------------------------------------------
   // Both lanes open; exit pass starts 'off' cycles after the entry pass.
   task automatic test_simultaneous(input int off);
      int  b_edge, pn, px, exp_ent, exp_ext;
      bit  un, ux;
      clear_hist();
      un = 1'($urandom); ux = 1'($urandom);
      ent_loop = 1; ext_loop = 1;
      ticks(D + 2);
      ent_tag_valid = 1; ent_tag_uni = un;
      ext_tag_valid = 1; ext_tag_uni = ux;
      uni_is_vacated_space = 1; is_vacated_space = 1;
      tick();
      ent_tag_valid = 0; ext_tag_valid = 0;
      b_edge = edge_n;
      for (int i = 0; i < D + 8; i++) begin
         ent_pass = (i >= 2) && (i < 2 + D);
         ext_pass = (i >= 2 + off) && (i < 2 + off + D);
         tick();
      end
      ent_pass = 0; ext_pass = 0; ent_loop = 0; ext_loop = 0;
      ticks(OC + 2 * D);
      pn = b_edge + 3 + D - 1;
      px = b_edge + 3 + off + D - 1;
      exp_ext = px + 1;
      exp_ent = (pn == px) ? pn + 2 : pn + 1;
      checks++;
      if (ent_ev.size() != 1 || ext_ev.size() != 1) begin
         errors++;
         $display("FAIL simul_counts: got entries=%0d exits=%0d expected 1/1", ent_ev.size(), ext_ev.size());
      end else begin
         checks++;
         if (ext_ev[0] != exp_ext || ext_ev_uni[0] != ux) begin
            errors++;
            $display("FAIL simul_exit: got edge %0d uni %0d expected edge %0d uni %0d",
                     ext_ev[0], ext_ev_uni[0], exp_ext, ux);
         end
         checks++;
         if (ent_ev[0] != exp_ent || ent_ev_uni[0] != un) begin
            errors++;
            $display("FAIL simul_entry: got edge %0d uni %0d expected edge %0d uni %0d",
                     ent_ev[0], ent_ev_uni[0], exp_ent, un);
         end
      end
      checks++;
      if (overlap_n != 0 || stray_n != 0) begin
         errors++;
         $display("FAIL simul_overlap: got overlap=%0d stray=%0d expected 0/0", overlap_n, stray_n);
      end
      $display("[simul] off=%0d entry_edge=%0d exit_edge=%0d",
               off, (ent_ev.size() > 0) ? ent_ev[0] : -1, (ext_ev.size() > 0) ? ext_ev[0] : -1);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_during_open();
      clear_hist();
      ent_loop = 1;
      ticks(D + 2);
      ent_tag_valid = 1; ent_tag_uni = 1; uni_is_vacated_space = 1;
      tick();
      ent_tag_valid = 0;
      ticks(2);
      ent_pass = 1;
      ticks(2);
      reset = 0;
      tick();
      checks++;
      if (ent_barrier_open !== 1'b0 || car_entered !== 1'b0 || ent_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_open_outputs: got barrier=%b entered=%b timeout=%b expected 0/0/0",
                  ent_barrier_open, car_entered, ent_timeout);
      end
      tick();
      reset = 1;
      drive_quiet();
      ticks(OC + 3 * D);
      checks++;
      if (ent_ev.size() != 0 || ext_ev.size() != 0 || ent_to.size() != 0 || ent_barrier_open !== 1'b0) begin
         errors++;
         $display("FAIL reset_open_aftermath: got entries=%0d exits=%0d timeouts=%0d barrier=%b expected 0/0/0/0",
                  ent_ev.size(), ext_ev.size(), ent_to.size(), ent_barrier_open);
      end
      $display("[reset_open] entries=%0d timeouts=%0d", ent_ev.size(), ent_to.size());
   endtask

   // ---------------------------------------------------------------------
   task automatic test_random_traffic();
      for (int n = 0; n < 10; n++) begin
         test_entry(1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, OC)), int'($urandom_range(1, D + 2)), "random");
      end
      for (int n = 0; n < 5; n++) begin
         test_exit(1'($urandom), int'($urandom_range(0, OC)), int'($urandom_range(1, D + 2)));
      end
      for (int n = 0; n < 4; n++) begin
         test_simultaneous(int'($urandom_range(0, 4)) - 2);
      end
   endtask

   initial begin
      drive_quiet();
      reset = 0;
      test_reset();
      test_entry(1, 1, 0, 2, D, "uni_entry");
      test_entry(0, 1, 0, 0, D, "full_lot");
      test_entry(0, 0, 1, 3, 3, "glitch");
      test_entry(1, 1, 1, OC - D - 1, D, "pass_at_expiry");
      test_entry(0, 0, 1, OC - D, D, "pass_after_expiry");
      test_exit(1, 1, D);
      test_exit(0, 2, 2);
      test_simultaneous(0);
      test_reset_during_open();
      test_random_traffic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
